aibcr3_dll_phdet_resp: RTL and testbench

Phase-detector responder for the AIB DLL calibration loop. It answers the DLL controller's `launch`/`measure` strobes by synchronizing the raw early/late comparator sample from the delay-line custom cell and majority-voting it over a bounded window. It returns a registered `t_up`/`t_down` decision with a deadband. It sits between the DLL custom macro and the DLL PNR controller, in the `clk_pll` domain.

---
 rtl/aibcr3_dll_phdet_resp.sv | 139 +++++++++++++
 tb/tb_aibcr3_dll_phdet_resp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/aibcr3_dll_phdet_resp.sv
// DLL phase-detector responder: synchronizes the comparator sample,
// majority-votes it over a bounded window and returns up/down with deadband.
module aibcr3_dll_phdet_resp #(
  parameter int WIN    = 8,
  parameter int HYST   = 1,
  parameter int SETTLE = 2,
  parameter int CW     = $clog2(WIN+1)
) (
  input  logic          clk_pll,
  input  logic          rst_pll,
  input  logic          dll_phdet_reset_n,
  input  logic          launch,
  input  logic          measure,
  input  logic          pd_sample,
  output logic          t_up,
  output logic          t_down,
  output logic          pd_valid,
  output logic          pd_busy,
  output logic [CW-1:0] pd_ones,
  output logic          pd_empty
);

  localparam int SW = $clog2(SETTLE+1);
  localparam int DW = CW + 2;

  typedef enum logic [1:0] {
    IDLE,
    SETL,
    ACCUM,
    DECIDE
  } state_t;

  state_t        state;
  logic          s1;
  logic          s_q;
  logic          launch_q;
  logic          lrise;
  logic [SW-1:0] scnt;
  logic [CW-1:0] ones;
  logic [CW-1:0] total;
  logic [DW-1:0] ones2;
  logic [DW-1:0] tot_w;
  logic [DW-1:0] hyst2;
  logic          up_c;
  logic          down_c;

  assign lrise = launch & ~launch_q;

  // Decision at widened width so 2*ones + 2*HYST never wraps
  always_comb begin
    ones2  = DW'(ones) << 1;
    tot_w  = DW'(total);
    hyst2  = DW'(2 * HYST);
    up_c   = ones2 > (tot_w + hyst2);
    down_c = (ones2 + hyst2) < tot_w;
  end

  // Two-flop sample synchronizer and launch edge register
  always_ff @(posedge clk_pll or posedge rst_pll) begin
    if (rst_pll) begin
      s1       <= 1'b0;
      s_q      <= 1'b0;
      launch_q <= 1'b0;
    end else if (!dll_phdet_reset_n) begin
      s1       <= 1'b0;
      s_q      <= 1'b0;
      launch_q <= 1'b0;
    end else begin
      s1       <= pd_sample;
      s_q      <= s1;
      launch_q <= launch;
    end
  end

  // Measurement FSM; a launch edge in any state restarts the window
  always_ff @(posedge clk_pll or posedge rst_pll) begin
    if (rst_pll) begin
      state    <= IDLE;
      scnt     <= '0;
      ones     <= '0;
      total    <= '0;
      t_up     <= 1'b0;
      t_down   <= 1'b0;
      pd_valid <= 1'b0;
      pd_busy  <= 1'b0;
      pd_ones  <= '0;
      pd_empty <= 1'b0;
    end else if (!dll_phdet_reset_n) begin
      state    <= IDLE;
      scnt     <= '0;
      ones     <= '0;
      total    <= '0;
      t_up     <= 1'b0;
      t_down   <= 1'b0;
      pd_valid <= 1'b0;
      pd_busy  <= 1'b0;
      pd_ones  <= '0;
      pd_empty <= 1'b0;
    end else begin
      pd_valid <= 1'b0;
      if (lrise) begin
        state   <= SETL;
        scnt    <= SW'(SETTLE - 1);
        ones    <= '0;
        total   <= '0;
        pd_busy <= 1'b1;
      end else begin
        unique case (state)
          IDLE: ;
          SETL: begin
            if (scnt == '0) state <= ACCUM;
            else            scnt  <= scnt - SW'(1);
          end
          ACCUM: begin
            if (measure) begin
              total <= total + CW'(1);
              ones  <= ones + CW'(s_q);
              if (total + CW'(1) == CW'(WIN))
                state <= DECIDE;
            end else if (total != '0) begin
              state <= DECIDE;
            end
          end
          DECIDE: begin
            t_up     <= up_c;
            t_down   <= down_c;
            pd_ones  <= ones;
            pd_empty <= (total == '0);
            pd_valid <= 1'b1;
            pd_busy  <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aibcr3_dll_phdet_resp.sv
// Randomized bench for the DLL phase-detector responder,
// checked against a per-window arithmetic reference model.
module tb_aibcr3_dll_phdet_resp;

  localparam int WIN    = 8;
  localparam int HYST   = 1;
  localparam int SETTLE = 2;
  localparam int CW     = $clog2(WIN+1);

  logic          clk_pll = 1'b0;
  logic          rst_pll;
  logic          dll_phdet_reset_n;
  logic          launch;
  logic          measure;
  logic          pd_sample;
  logic          t_up;
  logic          t_down;
  logic          pd_valid;
  logic          pd_busy;
  logic [CW-1:0] pd_ones;
  logic          pd_empty;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_up   = 0;
  int exp_dn   = 0;
  int exp_ones = 0;

  always #5 clk_pll = ~clk_pll;

  aibcr3_dll_phdet_resp #(
    .WIN(WIN), .HYST(HYST), .SETTLE(SETTLE)
  ) dut (
    .clk_pll(clk_pll),
    .rst_pll(rst_pll),
    .dll_phdet_reset_n(dll_phdet_reset_n),
    .launch(launch),
    .measure(measure),
    .pd_sample(pd_sample),
    .t_up(t_up),
    .t_down(t_down),
    .pd_valid(pd_valid),
    .pd_busy(pd_busy),
    .pd_ones(pd_ones),
    .pd_empty(pd_empty)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pll);
    @(negedge clk_pll);
  endtask

  task automatic idle(input int n);
    launch  = 1'b0;
    measure = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_valid", pd_valid, 0);
    end
  endtask

  function automatic logic [31:0] mkpat(input int k);
    logic [31:0] p;
    p = (32'd1 << k) - 32'd1;
    return p << 2;
  endfunction

  // One measurement: launch rises before edge 1; if ab>0, a second rise
  // before edge ab aborts and restarts. pat[e] is pd_sample before edge e.
  // A window starting at edge b counts pat[b+1 .. b+n] (2-cycle sync,
  // SETTLE cycles skipped), closing with pd_valid at b+11 (full) or b+4+n.
  task automatic window(input logic [31:0] pat, input int n, input int ab);
    int b, nn, vedge, ones, up, dn;
    b     = (ab == 0) ? 1 : ab;
    nn    = (n > WIN) ? WIN : n;
    vedge = (nn == WIN) ? b + 3 + WIN : b + 4 + nn;
    ones  = 0;
    for (int i = 1; i <= nn; i++) ones += int'(pat[b+i]);
    up = (2*ones > nn + 2*HYST) ? 1 : 0;
    dn = (2*ones + 2*HYST < nn) ? 1 : 0;
    for (int e = 1; e <= vedge + 2; e++) begin
      launch    = (ab != 0 && e == ab - 1) ? 1'b0 : 1'b1;
      measure   = (e < b + 3 + n);
      pd_sample = pat[e];
      step();
      if (e == b) chk("busy_on", pd_busy, 1);
      if (e == vedge - 1) begin
        chk("held_up", t_up, exp_up);
        chk("held_dn", t_down, exp_dn);
      end
      if (e == vedge) begin
        exp_up   = up;
        exp_dn   = dn;
        exp_ones = ones;
        chk("valid", pd_valid, 1);
        chk("t_up", t_up, exp_up);
        chk("t_down", t_down, exp_dn);
        chk("pd_ones", pd_ones, exp_ones);
        chk("pd_empty", pd_empty, 0);
        chk("busy_off", pd_busy, 0);
      end else begin
        chk("spurious_valid", pd_valid, 0);
      end
    end
    idle(2);
  endtask

  initial begin
    logic [31:0] p;
    int n, ab;
    rst_pll           = 1'b1;
    dll_phdet_reset_n = 1'b1;
    launch            = 1'b0;
    measure           = 1'b0;
    pd_sample         = 1'b0;
    step();
    step();
    chk("rst_up", t_up, 0);
    chk("rst_dn", t_down, 0);
    chk("rst_valid", pd_valid, 0);
    chk("rst_busy", pd_busy, 0);
    chk("rst_ones", pd_ones, 0);
    chk("rst_empty", pd_empty, 0);
    rst_pll = 1'b0;
    idle(2);

    window(32'hFFFF_FFFF, 8, 0);
    window(32'h0, 8, 0);
    window(mkpat(5), 8, 0);
    window(mkpat(6), 8, 0);
    window(mkpat(2), 8, 0);
    window(mkpat(3), 4, 0);
    window(32'hFFFF_FFFF, 8, 0);
    window(32'h0000_0000, 8, 7);

    for (int k = 0; k < 30; k++) begin
      p  = $urandom;
      n  = $urandom_range(1, 10);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 12) : 0;
      window(p, n, ab);
    end

    // synchronous clear mid-accumulation
    window(32'hFFFF_FFFF, 8, 0);
    for (int e = 1; e <= 6; e++) begin
      launch    = 1'b1;
      measure   = 1'b1;
      pd_sample = 1'b1;
      step();
    end
    launch            = 1'b0;
    dll_phdet_reset_n = 1'b0;
    step();
    chk("sclr_up", t_up, 0);
    chk("sclr_dn", t_down, 0);
    chk("sclr_ones", pd_ones, 0);
    chk("sclr_busy", pd_busy, 0);
    dll_phdet_reset_n = 1'b1;
    exp_up   = 0;
    exp_dn   = 0;
    exp_ones = 0;
    idle(14);
    chk("sclr_busy_after", pd_busy, 0);

    // asynchronous reset pulse mid-cycle
    window(32'hFFFF_FFFF, 8, 0);
    for (int e = 1; e <= 6; e++) begin
      launch    = 1'b1;
      measure   = 1'b1;
      pd_sample = 1'b1;
      step();
    end
    #2 rst_pll = 1'b1;
    #1;
    chk("arst_up", t_up, 0);
    chk("arst_ones", pd_ones, 0);
    chk("arst_busy", pd_busy, 0);
    launch = 1'b0;
    @(negedge clk_pll);
    rst_pll = 1'b0;
    exp_up   = 0;
    exp_dn   = 0;
    exp_ones = 0;
    idle(14);
    chk("arst_up_after", t_up, 0);

    window(mkpat(2), 8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
